// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared constants and types for the multi-cycle divider.
//             Holds the 2-bit divider state codes, ready/start encodings and
//             the double-width result bus type.
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Divider FSM state codes
    localparam logic [1:0] DivFree   = 2'b00;
    localparam logic [1:0] DivByZero = 2'b01;
    localparam logic [1:0] DivOn     = 2'b10;
    localparam logic [1:0] DivEnd    = 2'b11;

    // Result-ready flag encodings
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    // Start request encodings
    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    // {remainder, quotient} bus
    localparam int DOUBLE_REG_BUS_MSB = 63;
    typedef logic [DOUBLE_REG_BUS_MSB:0] double_reg_bus_t;

    typedef enum logic [1:0] {
        ST_FREE   = DivFree,
        ST_BYZERO = DivByZero,
        ST_ON     = DivOn,
        ST_END    = DivEnd
    } div_state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div.sv
`default_nettype none
// ============================================================================
//  Module   : div
//  Purpose  : Multi-cycle 32-bit restoring divider (one quotient bit per
//             clock) sitting beside the EX stage. Supports signed (DIV) and
//             unsigned (DIVU) operation; divide-by-zero returns zero.
//  Ports    : clk           - clock, rising edge
//             rst           - synchronous active-high reset
//             signed_div_i  - 1 = two's-complement divide, 0 = unsigned
//             opdata1_i     - dividend
//             opdata2_i     - divisor
//             start_i       - divide request, held until ready_o
//             annul_i       - abort an in-flight divide
//             result_o      - {remainder, quotient}, registered
//             ready_o       - result valid, registered
//  Revision : 1.0 - initial release
// ============================================================================
module div
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    div_state_e         state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    // {partial remainder, dividend/quotient}. The 65th bit of the working
    // register is only ever needed on the final step, where it is taken
    // straight from the step logic, so it is not stored.
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   divisor_q, divisor_d;
    logic               sign_quo_q, sign_quo_d;
    logic               sign_rem_q, sign_rem_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               ready_q, ready_d;

    logic [WIDTH-1:0]   w_op1_mag;
    logic [WIDTH-1:0]   w_op2_mag;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH:0]   w_step;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;

    // Magnitudes of the operands for signed mode
    assign w_op1_mag = (signed_div_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_op2_mag = (signed_div_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + 1'b1) : opdata2_i;

    // One restoring step: trial subtract; a borrow (bit WIDTH) means keep
    // the old partial remainder and shift in 0, otherwise keep the
    // difference and shift in 1.
    assign w_diff = {1'b0, work_q[2*WIDTH-1:WIDTH]} - {1'b0, divisor_q};
    assign w_step = w_diff[WIDTH] ? {work_q, 1'b0}
                                  : {w_diff[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};

    // Final sign correction applied on the last step
    assign w_quot = sign_quo_q ? (~w_step[WIDTH-1:0] + 1'b1) : w_step[WIDTH-1:0];
    assign w_rem  = sign_rem_q ? (~w_step[2*WIDTH:WIDTH+1] + 1'b1) : w_step[2*WIDTH:WIDTH+1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FREE;
            cnt_q      <= 6'd0;
            work_q     <= '0;
            divisor_q  <= '0;
            sign_quo_q <= 1'b0;
            sign_rem_q <= 1'b0;
            result_q   <= '0;
            ready_q    <= DivResultNotReady;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            divisor_q  <= divisor_d;
            sign_quo_q <= sign_quo_d;
            sign_rem_q <= sign_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        divisor_d  = divisor_q;
        sign_quo_d = sign_quo_q;
        sign_rem_d = sign_rem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            ST_FREE: begin
                result_d = '0;
                ready_d  = DivResultNotReady;
                if (start_i == DivStart && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = ST_BYZERO;
                    end else begin
                        state_d    = ST_ON;
                        cnt_d      = 6'd0;
                        // Pre-shifted so the first dividend bit already
                        // sits in the partial remainder.
                        work_d     = {{(WIDTH-1){1'b0}}, w_op1_mag, 1'b0};
                        divisor_d  = w_op2_mag;
                        sign_quo_d = signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        sign_rem_d = signed_div_i & opdata1_i[WIDTH-1];
                    end
                end
            end
            ST_BYZERO: begin
                state_d  = ST_END;
                result_d = '0;
                ready_d  = DivResultReady;
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_FREE;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else begin
                    work_d = w_step[2*WIDTH-1:0];
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'(WIDTH-1)) begin
                        state_d  = ST_END;
                        result_d = {w_rem, w_quot};
                        ready_d  = DivResultReady;
                    end
                end
            end
            ST_END: begin
                if (start_i == DivStop) begin
                    state_d  = ST_FREE;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                state_d  = ST_FREE;
                result_d = '0;
                ready_d  = DivResultNotReady;
            end
        endcase
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule : div
`default_nettype wire

// File: tb/tb_div.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div
//  Purpose  : Directed self-checking bench for the div block.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div;

    logic        clk;
    logic        rst;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        start;
    logic        annul;
    logic [63:0] result;
    logic        ready;

    int n_cmp;
    int n_err;

    div #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (opdata1),
        .opdata2_i    (opdata2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Launch a divide, count edges until ready, check result, hold start
    // for `hold` extra cycles, then drop start and check outputs clear.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic sgn, input logic [63:0] exp,
                           input int exp_edges, input int hold);
        int  edges;
        logic got;
        @(negedge clk);
        opdata1    = a;
        opdata2    = b;
        signed_div = sgn;
        start      = 1'b1;
        edges      = 0;
        got        = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 1) begin
                // Operands after latching must not matter
                opdata1    = $urandom;
                opdata2    = $urandom | 32'h1;
                signed_div = ~sgn;
            end
            if (ready) got = 1'b1;
        end
        check({tag, "_latency"}, 64'(edges), 64'(exp_edges));
        check({tag, "_result"}, result, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_ready"}, {63'd0, ready}, 64'd1);
            check({tag, "_hold_result"}, result, exp);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, "_drop_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_drop_result"}, result, 64'd0);
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b1;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        start      = 1'b0;
        annul      = 1'b0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Unsigned and signed basics
        run_div("u100_7",  32'h64,       32'h7,        1'b0, 64'h00000002_0000000E, 33, 0);
        run_div("s-100_7", 32'hFFFFFF9C, 32'h7,        1'b1, 64'hFFFFFFFE_FFFFFFF2, 33, 0);
        run_div("s100_-7", 32'h64,       32'hFFFFFFF9, 1'b1, 64'h00000002_FFFFFFF2, 33, 0);

        // Divide by zero
        run_div("div0",    32'h1234,     32'h0,        1'b0, 64'h0, 2, 0);

        // Annul on the 10th ON cycle
        @(negedge clk);
        opdata1 = 32'h64; opdata2 = 32'h7; signed_div = 1'b0; start = 1'b1;
        @(posedge clk); #1;          // latch edge
        repeat (9) begin @(posedge clk); #1; end
        @(negedge clk);
        annul = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("annul_ready", {63'd0, ready}, 64'd0);
        check("annul_result", result, 64'd0);
        @(negedge clk);
        annul = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        check("annul_never_ready", {63'd0, ready}, 64'd0);
        run_div("u9_3",    32'h9,        32'h3,        1'b0, 64'h00000000_00000003, 33, 0);

        // Hold start 5 cycles past ready
        run_div("hold",    32'h64,       32'h7,        1'b0, 64'h00000002_0000000E, 33, 5);

        // Reset mid-operation
        @(negedge clk);
        opdata1 = 32'hFFFFFFFF; opdata2 = 32'h3; signed_div = 1'b0; start = 1'b1;
        repeat (15) begin @(posedge clk); #1; end
        @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready", {63'd0, ready}, 64'd0);
        check("midrst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div("post_rst", 32'h64,      32'h7,        1'b0, 64'h00000002_0000000E, 33, 0);

        // Boundary cases
        run_div("s_ovf",   32'h80000000, 32'hFFFFFFFF, 1'b1, 64'h00000000_80000000, 33, 0);
        run_div("u_max_1", 32'hFFFFFFFF, 32'h1,        1'b0, 64'h00000000_FFFFFFFF, 33, 0);
        run_div("u_max_16",32'hFFFFFFFF, 32'h10,       1'b0, 64'h0000000F_0FFFFFFF, 33, 0);
        run_div("s_-7_-2", 32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 64'hFFFFFFFF_00000003, 33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_div
`default_nettype wire
